// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;
    typedef enum logic [1:0] {
        S_ISSUE = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2,
        S_DROP  = 2'd3
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0;
    localparam int OPC_HI = 31;
    localparam int OPC_LO = 26;

    function automatic logic [5:0] opcode_of(input logic [31:0] instr);
        return instr[OPC_HI:OPC_LO];
    endfunction
endpackage

// File: rtl/instr_fetch_stage_if.sv
// Instruction-memory request/response bus: one request pulse, one response strobe.
interface instr_fetch_stage_if #(parameter int PC_W = 32) ();
    logic            req;
    logic [PC_W-1:0] addr;
    logic            rvalid;
    logic [31:0]     rdata;

    modport master (output req, output addr, input rvalid, input rdata);
    modport slave  (input req, input addr, output rvalid, output rdata);
endinterface

// File: rtl/ifid_reg.sv
// IF/ID pipeline register; flush beats load beats hold, otherwise a bubble is inserted.
module ifid_reg
    import fetch_pkg::*;
#(
    parameter int PC_W = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic            flush,
    input  logic            hold,
    input  logic [31:0]     load_instr,
    input  logic [PC_W-1:0] load_pc4,
    output logic            valid,
    output logic [31:0]     instr,
    output logic [PC_W-1:0] pc4
);
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid <= 1'b0;
            instr <= NOP_INSTR;
            pc4   <= '0;
        end else if (flush) begin
            valid <= 1'b0;
            instr <= NOP_INSTR;
        end else if (load) begin
            valid <= 1'b1;
            instr <= load_instr;
            pc4   <= load_pc4;
        end else if (!hold) begin
            valid <= 1'b0;
        end
    end
endmodule

// File: rtl/instr_fetch_stage.sv
// Fetch stage: PC, single-outstanding request FSM, stall hold buffer and IF/ID register.
module instr_fetch_stage
    import fetch_pkg::*;
#(
    parameter int              PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    instr_fetch_stage_if.master        imem,
    input  logic                       stall,
    input  logic                       redirect_valid,
    input  logic [PC_W-1:0]            redirect_pc,
    output logic                       ifid_valid,
    output logic [31:0]                ifid_instr,
    output logic [PC_W-1:0]            ifid_pc4,
    output logic [5:0]                 opcode
);
    localparam logic [PC_W-1:0] PC_STEP   = PC_W'(4);
    localparam logic [PC_W-1:0] WORD_MASK = ~PC_W'(3);

    fetch_state_t    state;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] pc_next4;
    logic [31:0]     hold_buf;
    logic [31:0]     load_instr;
    logic            load;

    assign pc_next4 = pc + PC_STEP;

    // The request is a Moore output of S_ISSUE, masked while reset is held.
    assign imem.req  = rst_n && (state == S_ISSUE);
    assign imem.addr = pc;

    assign load = !redirect_valid && !stall &&
                  (((state == S_WAIT) && imem.rvalid) || (state == S_HOLD));
    assign load_instr = (state == S_HOLD) ? hold_buf : imem.rdata;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_ISSUE;
            pc       <= RESET_PC;
            hold_buf <= NOP_INSTR;
        end else if (redirect_valid) begin
            pc <= redirect_pc & WORD_MASK;
            // A request still in flight must be swallowed in S_DROP before reissuing.
            case (state)
                S_ISSUE:        state <= S_DROP;
                S_HOLD:         state <= S_ISSUE;
                S_WAIT, S_DROP: state <= imem.rvalid ? S_ISSUE : S_DROP;
            endcase
        end else begin
            case (state)
                S_ISSUE: state <= S_WAIT;
                S_WAIT: begin
                    if (imem.rvalid) begin
                        if (stall) begin
                            hold_buf <= imem.rdata;
                            state    <= S_HOLD;
                        end else begin
                            state <= S_ISSUE;
                        end
                    end
                end
                S_HOLD:  if (!stall) state <= S_ISSUE;
                S_DROP:  if (imem.rvalid) state <= S_ISSUE;
            endcase
            if (load) pc <= pc_next4;
        end
    end

    ifid_reg #(.PC_W(PC_W)) u_ifid (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .flush      (redirect_valid),
        .hold       (stall),
        .load_instr (load_instr),
        .load_pc4   (pc_next4),
        .valid      (ifid_valid),
        .instr      (ifid_instr),
        .pc4        (ifid_pc4)
    );

    assign opcode = opcode_of(ifid_instr);
endmodule

// File: tb/tb_instr_fetch_stage.sv
// Bench for instr_fetch_stage: directed vector table, wrap-around instance, random run vs reference model.
module tb_instr_fetch_stage;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst, st, rd;
        logic [31:0] rpc;
        logic        rv;
        logic [31:0] rdat;
        logic        chk;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_v;
        logic [31:0] e_i, e_p4;
    } vec_t;

    logic        rst_n, stall, redir;
    logic [31:0] rpc;
    logic        v_a;
    logic [31:0] i_a, p_a;
    logic [5:0]  op_a;
    logic        rst_b;
    logic        v_b;
    logic [31:0] i_b, p_b;
    logic [5:0]  op_b;

    instr_fetch_stage_if #(.PC_W(32)) ifa ();
    instr_fetch_stage_if #(.PC_W(32)) ifb ();

    instr_fetch_stage #(.PC_W(32), .RESET_PC(32'h0000_0000)) dut_a (
        .clk(clk), .rst_n(rst_n), .imem(ifa), .stall(stall),
        .redirect_valid(redir), .redirect_pc(rpc),
        .ifid_valid(v_a), .ifid_instr(i_a), .ifid_pc4(p_a), .opcode(op_a));

    instr_fetch_stage #(.PC_W(32), .RESET_PC(32'hFFFF_FFFC)) dut_b (
        .clk(clk), .rst_n(rst_b), .imem(ifb), .stall(1'b0),
        .redirect_valid(1'b0), .redirect_pc(32'h0),
        .ifid_valid(v_b), .ifid_instr(i_b), .ifid_pc4(p_b), .opcode(op_b));

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_a(input string tag, input logic er, input logic [31:0] ea,
                           input logic ev, input logic [31:0] ei, input logic [31:0] ep);
        logic [31:0] w;
        w = ei;
        chk({tag, ".req"},    {31'b0, ifa.req}, {31'b0, er});
        chk({tag, ".addr"},   ifa.addr, ea);
        chk({tag, ".valid"},  {31'b0, v_a}, {31'b0, ev});
        chk({tag, ".instr"},  i_a, ei);
        chk({tag, ".pc4"},    p_a, ep);
        chk({tag, ".opcode"}, {26'b0, op_a}, {26'b0, w[31:26]});
    endtask

    function automatic vec_t mk(input logic r, input logic s, input logic d, input logic [31:0] rp,
                                input logic vi, input logic [31:0] rdat, input logic c,
                                input logic er, input logic [31:0] ea, input logic ev,
                                input logic [31:0] ei, input logic [31:0] ep);
        vec_t t;
        t.rst = r; t.st = s; t.rd = d; t.rpc = rp; t.rv = vi; t.rdat = rdat; t.chk = c;
        t.e_req = er; t.e_addr = ea; t.e_v = ev; t.e_i = ei; t.e_p4 = ep;
        return t;
    endfunction

    // Reference model: transaction-level flags rather than an FSM encoding.
    logic        m_busy, m_stale, m_hasbuf, m_v, m_req;
    logic [31:0] m_pc, m_buf, m_i, m_p4;
    logic        mem_pend;
    int          mem_cnt;

    task automatic model_step(input logic r, input logic s, input logic d, input logic [31:0] tp,
                              input logic rv, input logic [31:0] rdw);
        logic deliver;
        logic [31:0] w;
        deliver = 1'b0;
        w = 32'h0;
        if (!r) begin
            m_pc = 32'h0; m_busy = 0; m_stale = 0; m_hasbuf = 0;
            m_v = 0; m_i = 32'h0; m_p4 = 32'h0;
        end else begin
            if (m_req) begin
                m_busy = 1; m_stale = d;
            end else if (m_busy && rv) begin
                m_busy = 0;
                if (!m_stale && !d) begin
                    if (s) begin m_hasbuf = 1; m_buf = rdw; end
                    else begin deliver = 1; w = rdw; end
                end
                m_stale = 0;
            end else if (m_busy && d) begin
                m_stale = 1;
            end else if (m_hasbuf && !s) begin
                deliver = 1; w = m_buf; m_hasbuf = 0;
            end
            if (d) begin
                m_hasbuf = 0; m_pc = {tp[31:2], 2'b00}; m_v = 0; m_i = 32'h0;
            end else if (deliver) begin
                m_v = 1; m_i = w; m_p4 = m_pc + 32'd4; m_pc = m_pc + 32'd4;
            end else if (!s) begin
                m_v = 0;
            end
        end
    endtask

    vec_t tbl[27];

    initial begin
        rst_n = 0; stall = 0; redir = 0; rpc = 0;
        ifa.rvalid = 0; ifa.rdata = 0;
        rst_b = 0; ifb.rvalid = 0; ifb.rdata = 0;
        m_busy = 0; m_stale = 0; m_hasbuf = 0; m_v = 0; m_req = 0;
        m_pc = 0; m_buf = 0; m_i = 0; m_p4 = 0; mem_pend = 0; mem_cnt = 0;

        //          rst st rd rpc         rv rdata        chk req addr        v  instr         pc4
        tbl[0]  = mk(0, 0, 0, 32'h0,      0, 32'h0,        0, 0, 32'h0,      0, 32'h0,        32'h0);
        tbl[1]  = mk(0, 0, 0, 32'h0,      0, 32'h0,        1, 0, 32'h0,      0, 32'h0,        32'h0);
        tbl[2]  = mk(1, 0, 0, 32'h0,      0, 32'h0,        1, 1, 32'h0,      0, 32'h0,        32'h0);
        tbl[3]  = mk(1, 0, 0, 32'h0,      1, 32'h8C080004, 1, 0, 32'h0,      0, 32'h0,        32'h0);
        tbl[4]  = mk(1, 1, 0, 32'h0,      0, 32'h0,        1, 1, 32'h4,      1, 32'h8C080004, 32'h4);
        tbl[5]  = mk(1, 1, 0, 32'h0,      1, 32'h20080005, 1, 0, 32'h4,      1, 32'h8C080004, 32'h4);
        tbl[6]  = mk(1, 1, 0, 32'h0,      0, 32'h0,        1, 0, 32'h4,      1, 32'h8C080004, 32'h4);
        tbl[7]  = mk(1, 1, 0, 32'h0,      0, 32'h0,        1, 0, 32'h4,      1, 32'h8C080004, 32'h4);
        tbl[8]  = mk(1, 0, 0, 32'h0,      0, 32'h0,        1, 0, 32'h4,      1, 32'h8C080004, 32'h4);
        tbl[9]  = mk(1, 0, 0, 32'h0,      0, 32'h0,        1, 1, 32'h8,      1, 32'h20080005, 32'h8);
        tbl[10] = mk(1, 0, 1, 32'h43,     0, 32'h0,        1, 0, 32'h8,      0, 32'h20080005, 32'h8);
        tbl[11] = mk(1, 0, 0, 32'h0,      0, 32'h0,        1, 0, 32'h40,     0, 32'h0,        32'h8);
        tbl[12] = mk(1, 0, 0, 32'h0,      1, 32'hDEADBEEF, 1, 0, 32'h40,     0, 32'h0,        32'h8);
        tbl[13] = mk(1, 0, 0, 32'h0,      0, 32'h0,        1, 1, 32'h40,     0, 32'h0,        32'h8);
        tbl[14] = mk(1, 0, 0, 32'h0,      1, 32'h3C011234, 1, 0, 32'h40,     0, 32'h0,        32'h8);
        tbl[15] = mk(1, 0, 0, 32'h0,      0, 32'h0,        1, 1, 32'h44,     1, 32'h3C011234, 32'h44);
        tbl[16] = mk(1, 0, 1, 32'h100,    1, 32'h11112222, 1, 0, 32'h44,     0, 32'h3C011234, 32'h44);
        tbl[17] = mk(1, 0, 0, 32'h0,      0, 32'h0,        1, 1, 32'h100,    0, 32'h0,        32'h44);
        tbl[18] = mk(1, 0, 0, 32'h0,      1, 32'h08000010, 1, 0, 32'h100,    0, 32'h0,        32'h44);
        tbl[19] = mk(1, 0, 1, 32'h200,    0, 32'h0,        1, 1, 32'h104,    1, 32'h08000010, 32'h104);
        tbl[20] = mk(1, 0, 0, 32'h0,      1, 32'hBAD00000, 1, 0, 32'h200,    0, 32'h0,        32'h104);
        tbl[21] = mk(1, 0, 0, 32'h0,      0, 32'h0,        1, 1, 32'h200,    0, 32'h0,        32'h104);
        tbl[22] = mk(0, 0, 0, 32'h0,      0, 32'h0,        1, 0, 32'h200,    0, 32'h0,        32'h104);
        tbl[23] = mk(0, 0, 0, 32'h0,      1, 32'hFFFFFFFF, 1, 0, 32'h0,      0, 32'h0,        32'h0);
        tbl[24] = mk(1, 0, 0, 32'h0,      0, 32'h0,        1, 1, 32'h0,      0, 32'h0,        32'h0);
        tbl[25] = mk(1, 0, 0, 32'h0,      1, 32'h8C080004, 1, 0, 32'h0,      0, 32'h0,        32'h0);
        tbl[26] = mk(1, 0, 0, 32'h0,      0, 32'h0,        1, 1, 32'h4,      1, 32'h8C080004, 32'h4);

        for (int k = 0; k < 27; k++) begin
            @(posedge clk); #1;
            rst_n = tbl[k].rst; stall = tbl[k].st; redir = tbl[k].rd; rpc = tbl[k].rpc;
            ifa.rvalid = tbl[k].rv; ifa.rdata = tbl[k].rdat;
            @(negedge clk);
            if (tbl[k].chk)
                check_a($sformatf("vec%0d", k), tbl[k].e_req, tbl[k].e_addr,
                        tbl[k].e_v, tbl[k].e_i, tbl[k].e_p4);
        end

        // PC wrap: fetch from 0xFFFF_FFFC, next request must be at 0.
        @(posedge clk); #1; rst_b = 1;
        @(negedge clk);
        chk("wrap.req0",  {31'b0, ifb.req}, 32'h1);
        chk("wrap.addr0", ifb.addr, 32'hFFFF_FFFC);
        chk("wrap.valid0", {31'b0, v_b}, 32'h0);
        @(posedge clk); #1; ifb.rvalid = 1; ifb.rdata = 32'h2402_0007;
        @(negedge clk);
        chk("wrap.req1", {31'b0, ifb.req}, 32'h0);
        @(posedge clk); #1; ifb.rvalid = 0;
        @(negedge clk);
        chk("wrap.req2",  {31'b0, ifb.req}, 32'h1);
        chk("wrap.addr2", ifb.addr, 32'h0);
        chk("wrap.valid2", {31'b0, v_b}, 32'h1);
        chk("wrap.instr2", i_b, 32'h2402_0007);
        chk("wrap.pc4",    p_b, 32'h0);
        chk("wrap.opcode", {26'b0, op_b}, 32'h9);

        // Random traffic with a variable-latency single-outstanding memory.
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            rst_n = (c < 2) ? 1'b0 : ($urandom_range(0, 99) != 0);
            stall = ($urandom_range(0, 99) < 30);
            redir = ($urandom_range(0, 99) < 8);
            rpc   = $urandom;
            ifa.rvalid = mem_pend && (mem_cnt == 0);
            ifa.rdata  = $urandom;
            m_req = rst_n && !m_busy && !m_hasbuf;
            @(negedge clk);
            if (c > 0) check_a($sformatf("rnd%0d", c), m_req, m_pc, m_v, m_i, m_p4);
            if (ifa.rvalid) mem_pend = 0;
            else if (mem_pend) mem_cnt--;
            if (!rst_n) mem_pend = 0;
            if (ifa.req) begin
                mem_pend = 1;
                mem_cnt  = $urandom_range(0, 3);
            end
            model_step(rst_n, stall, redir, rpc, ifa.rvalid, ifa.rdata);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
